// File: rtl/req_sched.sv
// req_sched: round-robin scheduler that drains NQ first-word-fall-through FIFOs,
// one whole DELIM-terminated request at a time, into a registered ready/valid output.
module req_sched #(
    parameter int unsigned NQ      = 4,
    parameter int unsigned WIDTH   = 64,
    parameter logic [7:0]  DELIM   = 8'hee,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NQ-1:0]           q_empty,
    input  logic [NQ*WIDTH-1:0]     q_data,
    output logic [NQ-1:0]           q_rd,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sop,
    output logic                    out_eop,
    output logic [$clog2(NQ)-1:0]   out_qid,
    output logic                    abort,
    output logic                    busy
);

    localparam int unsigned QW = $clog2(NQ);
    localparam int unsigned CW = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t             r_state;
    logic [QW-1:0]      r_grant;
    logic [QW-1:0]      r_last;
    logic [CW-1:0]      r_cnt;
    logic               r_first;
    logic [WIDTH-1:0]   r_data;
    logic               r_valid;
    logic               r_sop;
    logic               r_eop;
    logic [QW-1:0]      r_qid;
    logic               r_abort;

    logic [QW-1:0]      w_pick;
    logic [QW-1:0]      w_idx;
    logic               w_hit;
    logic [WIDTH-1:0]   w_frame;
    logic               w_delim;
    logic               w_pop;
    logic               w_starve;
    logic               w_timeout;

    // Round-robin search starting just after the previous grant.
    always_comb begin
        w_hit  = 1'b0;
        w_pick = r_last;
        w_idx  = '0;
        for (int k = 1; k <= int'(NQ); k++) begin
            w_idx = QW'((int'(r_last) + k) % int'(NQ));
            if (!w_hit && !q_empty[w_idx]) begin
                w_hit  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    assign w_frame   = q_data[32'(r_grant) * WIDTH +: WIDTH];
    assign w_delim   = (w_frame[7:0] == DELIM);
    assign w_pop     = (r_state == S_LOCK) && !q_empty[r_grant] && (!r_valid || out_ready);
    assign w_starve  = (r_state == S_LOCK) && q_empty[r_grant];
    assign w_timeout = w_starve && (r_cnt == CW'(TIMEOUT - 1));

    // Pop strobe must follow the FIFO head in the same cycle, so it is decoded, not registered.
    always_comb begin
        q_rd = '0;
        if (w_pop) begin
            q_rd[r_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= QW'(NQ - 1);
            r_cnt   <= '0;
            r_first <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_qid   <= '0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= 1'b0;

            // Output register: load on pop, otherwise drain when accepted.
            if (w_pop) begin
                r_data  <= w_frame;
                r_valid <= 1'b1;
                r_sop   <= r_first;
                r_eop   <= w_delim;
                r_qid   <= r_grant;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_hit) begin
                        r_state <= S_LOCK;
                        r_grant <= w_pick;
                        r_first <= 1'b1;
                    end
                end
                S_LOCK: begin
                    if (w_pop) begin
                        r_first <= 1'b0;
                        r_cnt   <= '0;
                        if (w_delim) begin
                            r_state <= S_IDLE;
                            r_last  <= r_grant;
                        end
                    end else if (w_timeout) begin
                        // Abandon the stalled request; no frame is emitted for it.
                        r_abort <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_last  <= r_grant;
                    end else if (w_starve) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_sop   = r_sop;
    assign out_eop   = r_eop;
    assign out_qid   = r_qid;
    assign abort     = r_abort;
    assign busy      = (r_state == S_LOCK);

endmodule

// File: tb/tb_req_sched.sv
// Bench for req_sched: queue-based FIFO models feed the DUT and a request-level
// round-robin model predicts the output frame stream.
module tb_req_sched;

    localparam int unsigned NQ  = 4;
    localparam int unsigned W   = 64;
    localparam logic [7:0]  DLM = 8'hee;
    localparam int unsigned TMO = 10;

    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   q;
        logic         sop;
        logic         eop;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NQ-1:0]   q_empty;
    logic [NQ*W-1:0] q_data;
    logic [NQ-1:0]   q_rd;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_sop;
    logic            out_eop;
    logic [1:0]      out_qid;
    logic            abort;
    logic            busy;

    int            n_chk = 0;
    int            n_err = 0;
    int            ncyc  = 0;
    int            mlast = 3;
    logic [W-1:0]  fq [NQ][$];
    exp_t          eq [$];
    int            acc_cyc [$];
    logic [1:0]    acc_q [$];
    logic [NQ-1:0] rd_lat    = '0;
    logic          rnd_ready = 1'b0;
    logic          rdy_val   = 1'b1;
    logic          p_stall   = 1'b0;
    logic [W-1:0]  p_data    = '0;
    logic [3:0]    p_ctl     = '0;

    req_sched #(
        .NQ      (NQ),
        .WIDTH   (W),
        .DELIM   (DLM),
        .TIMEOUT (TMO)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .q_empty   (q_empty),
        .q_data    (q_data),
        .q_rd      (q_rd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_qid   (out_qid),
        .abort     (abort),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, ncyc);
        end
    endtask

    function automatic logic [W-1:0] mkf(input logic last);
        logic [W-1:0] f;
        f = {$urandom, $urandom};
        if (last) f[7:0] = DLM;
        else if (f[7:0] == DLM) f[7:0] = 8'h00;
        return f;
    endfunction

    task automatic load_req(input int qi, input int len);
        for (int j = 0; j < len; j++) fq[qi].push_back(mkf(j == len - 1));
    endtask

    task automatic drive_q();
        for (int i = 0; i < int'(NQ); i++) begin
            q_empty[i]        = (fq[i].size() == 0);
            q_data[i*W +: W]  = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endtask

    // Reference: whole requests leave in round-robin order of non-empty FIFOs.
    task automatic build_expect(input int start_last, output int end_last);
        logic [W-1:0] cp [NQ][$];
        logic [W-1:0] f;
        exp_t e;
        int last, pick;
        logic found, first;
        last = start_last;
        for (int i = 0; i < int'(NQ); i++) cp[i] = fq[i];
        while (1) begin
            found = 1'b0;
            pick  = 0;
            for (int k = 1; k <= int'(NQ); k++) begin
                if (!found && cp[(last + k) % int'(NQ)].size() != 0) begin
                    found = 1'b1;
                    pick  = (last + k) % int'(NQ);
                end
            end
            if (!found) break;
            first = 1'b1;
            do begin
                f     = cp[pick].pop_front();
                e.d   = f;
                e.q   = 2'(pick);
                e.sop = first;
                e.eop = (f[7:0] == DLM);
                eq.push_back(e);
                first = 1'b0;
            end while (!e.eop && cp[pick].size() != 0);
            last = pick;
        end
        end_last = last;
    endtask

    task automatic monitor();
        exp_t e;
        chk("rd_onehot", 64'($onehot0(q_rd)), 64'd1);
        chk("rd_empty", 64'(q_rd & q_empty), 64'd0);
        if (out_valid && !out_ready) chk("rd_stall", 64'(q_rd), 64'd0);
        if (p_stall) begin
            chk("hold_data", out_data, p_data);
            chk("hold_ctl", 64'({out_valid, out_sop, out_eop, out_qid}), 64'({1'b1, p_ctl}));
        end
        if (out_valid && out_ready) begin
            if (eq.size() == 0) begin
                chk("extra_frame", 64'(eq.size()), 64'd1);
            end else begin
                e = eq.pop_front();
                chk("frame_data", out_data, e.d);
                chk("frame_ctl", 64'({out_sop, out_eop, out_qid}), 64'({e.sop, e.eop, e.q}));
            end
            acc_cyc.push_back(ncyc);
            acc_q.push_back(out_qid);
        end
        p_stall = out_valid && !out_ready;
        p_data  = out_data;
        p_ctl   = {out_sop, out_eop, out_qid};
    endtask

    // One clock: apply pops seen last cycle, drive inputs, then sample at the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NQ); i++)
            if (rd_lat[i] && fq[i].size() != 0) fq[i].delete(0);
        drive_q();
        out_ready = rnd_ready ? ($urandom_range(0, 99) < 70) : rdy_val;
        ncyc++;
        @(negedge clk);
        monitor();
        rd_lat = q_rd;
    endtask

    task automatic run_done(input int maxc, input string tag);
        int n;
        int left;
        n = 0;
        while ((eq.size() != 0 || busy || out_valid) && n < maxc) begin
            cyc();
            n++;
        end
        left = 0;
        for (int i = 0; i < int'(NQ); i++) left += fq[i].size();
        chk({tag, "_done"}, 64'(n < maxc), 64'd1);
        chk({tag, "_drain"}, 64'(left), 64'd0);
    endtask

    task automatic clr_acc();
        acc_cyc.delete();
        acc_q.delete();
    endtask

    initial begin
        int t0, tp, ta, nab;
        logic bz;

        // Reset and idle behaviour
        reset_n   = 1'b0;
        out_ready = 1'b1;
        drive_q();
        repeat (2) @(negedge clk);
        chk("rst_data", out_data, 64'd0);
        chk("rst_ctl", 64'({out_valid, out_sop, out_eop, out_qid, abort, busy, q_rd}), 64'd0);
        reset_n = 1'b1;
        repeat (3) cyc();
        chk("idle_empty_busy", 64'(busy), 64'd0);

        // Single three-frame request on FIFO 2
        load_req(2, 3);
        build_expect(mlast, mlast);
        clr_acc();
        t0 = ncyc;
        cyc();
        chk("single_arb_busy", 64'(busy), 64'd0);
        chk("single_arb_rd", 64'(q_rd), 64'd0);
        cyc();
        chk("single_lock_busy", 64'(busy), 64'd1);
        chk("single_lock_rd", 64'(q_rd), 64'b0100);
        run_done(50, "single");
        chk("single_count", 64'(acc_cyc.size()), 64'd3);
        chk("single_first_cyc", 64'(acc_cyc[0] - t0), 64'd3);
        chk("single_last_cyc", 64'(acc_cyc[2] - t0), 64'd5);

        // One-frame request on FIFO 1
        load_req(1, 1);
        build_expect(mlast, mlast);
        clr_acc();
        run_done(50, "oneframe");
        chk("oneframe_count", 64'(acc_cyc.size()), 64'd1);
        chk("oneframe_qid", 64'(acc_q[0]), 64'd1);

        // Round-robin between FIFOs 0 and 1, two 2-frame requests each
        load_req(0, 2); load_req(0, 2);
        load_req(1, 2); load_req(1, 2);
        build_expect(mlast, mlast);
        clr_acc();
        run_done(100, "rr");
        chk("rr_count", 64'(acc_cyc.size()), 64'd8);
        for (int k = 1; k < 4; k++)
            chk("rr_gap", 64'(acc_cyc[2*k] - acc_cyc[2*k-1]), 64'd2);

        // Backpressure for 5 cycles mid-request on FIFO 3
        load_req(3, 4);
        build_expect(mlast, mlast);
        clr_acc();
        for (int n = 0; n < 20 && acc_cyc.size() < 2; n++) cyc();
        rdy_val = 1'b0;
        repeat (5) cyc();
        chk("bp_no_accept", 64'(acc_cyc.size()), 64'd2);
        rdy_val = 1'b1;
        run_done(50, "bp");
        chk("bp_count", 64'(acc_cyc.size()), 64'd4);

        // Starvation: FIFO 3 empties after a non-DELIM frame
        begin
            exp_t e;
            fq[3].push_back(mkf(1'b0));
            e.d = fq[3][0]; e.q = 2'd3; e.sop = 1'b1; e.eop = 1'b0;
            eq.push_back(e);
        end
        clr_acc();
        tp = -1;
        for (int n = 0; n < 10 && tp < 0; n++) begin
            cyc();
            if (q_rd[3]) tp = ncyc;
        end
        chk("starve_pop_seen", 64'(tp >= 0), 64'd1);
        ta  = -1;
        nab = 0;
        bz  = 1'b1;
        for (int n = 0; n < 16; n++) begin
            cyc();
            if (abort) begin
                nab++;
                if (ta < 0) begin
                    ta = ncyc;
                    bz = busy;
                end
            end
        end
        chk("abort_pulses", 64'(nab), 64'd1);
        // 10 empty cycles after the popped frame appears, i.e. 11 samples after q_rd
        chk("abort_latency", 64'(ta - tp), 64'(TMO + 1));
        chk("abort_busy", 64'(bz), 64'd0);
        chk("abort_no_frame", 64'(acc_cyc.size()), 64'd1);
        mlast = 3;
        load_req(0, 1);
        load_req(3, 1);
        build_expect(mlast, mlast);
        clr_acc();
        run_done(50, "post_abort");
        chk("post_abort_grant", 64'(acc_q[0]), 64'd0);

        // Reset mid-request on FIFO 2 while FIFOs 1 and 3 are waiting
        load_req(2, 6);
        build_expect(mlast, mlast);
        clr_acc();
        for (int n = 0; n < 20 && acc_cyc.size() < 2; n++) cyc();
        load_req(1, 2);
        load_req(3, 1);
        cyc();
        cyc();
        chk("mid_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_data", out_data, 64'd0);
        chk("midrst_ctl", 64'({out_valid, out_sop, out_eop, out_qid, abort, busy, q_rd}), 64'd0);
        fq[2].delete();
        eq.delete();
        p_stall = 1'b0;
        rd_lat  = '0;
        cyc();
        reset_n = 1'b1;
        mlast   = 3;
        build_expect(mlast, mlast);
        clr_acc();
        run_done(50, "after_rst");
        chk("after_rst_grant", 64'(acc_q[0]), 64'd1);

        // Randomized rounds with random backpressure
        rnd_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < int'(NQ); i++)
                for (int j = 0, nr = $urandom_range(0, 3); j < nr; j++)
                    load_req(i, $urandom_range(1, 4));
            build_expect(mlast, mlast);
            run_done(2000, "rand");
        end
        rnd_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
